paula_floppy_mfm_deser: RTL

//  Upstream stage of the floppy DMA read FIFO. Takes the serial MFM bitstream from the drive

---
 rtl/paula_floppy_mfm_deser_if.sv | 32 +++
 rtl/paula_floppy_mfm_deser.sv | 127 ++++++++++++
 2 files changed

// File: rtl/paula_floppy_mfm_deser_if.sv
// Handshake bundle between the MFM deserializer, the drive model, the floppy FIFO and Paula regs.
// master drives the stimulus side, slave is the deserializer itself.
interface paula_floppy_mfm_deser_if #(parameter int LEN_W = 14);
  logic             i_clk7_en;
  logic             i_bit_stb;
  logic             i_bit_in;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_dma_en;
  logic             i_wordsync;
  logic [15:0]      i_dsksync;
  logic             i_fifo_full;
  logic [15:0]      o_fifo_in;
  logic             o_fifo_wr;
  logic             o_busy;
  logic [LEN_W-1:0] o_words_left;
  logic             o_blk_done;
  logic             o_overrun;
  logic             o_sync_irq;

  modport master (
    output i_clk7_en, i_bit_stb, i_bit_in, i_start, i_len, i_dma_en, i_wordsync, i_dsksync,
           i_fifo_full,
    input  o_fifo_in, o_fifo_wr, o_busy, o_words_left, o_blk_done, o_overrun, o_sync_irq
  );

  modport slave (
    input  i_clk7_en, i_bit_stb, i_bit_in, i_start, i_len, i_dma_en, i_wordsync, i_dsksync,
           i_fifo_full,
    output o_fifo_in, o_fifo_wr, o_busy, o_words_left, o_blk_done, o_overrun, o_sync_irq
  );
endinterface

// File: rtl/paula_floppy_mfm_deser.sv
// Floppy MFM deserializer: sync hunt, 16-bit word packing, block length count, overrun flag.
// Optional FLOPPY_SYNC_IRQ_EN enables the DSKSYN sync-match interrupt pulse on o_sync_irq.
module paula_floppy_mfm_deser #(
  parameter int LEN_W = 14
) (
  input logic                     i_clk,
  input logic                     i_reset,
  paula_floppy_mfm_deser_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_XFER} state_t;

  state_t           r_state, w_state_nxt;
  logic [14:0]      r_sr;
  logic [3:0]       r_bitcnt, w_bitcnt_nxt;
  logic [LEN_W-1:0] r_words_left, w_left_nxt;
  logic [15:0]      r_fifo_in, w_fifo_in_nxt;
  logic             r_fifo_wr, w_wr_nxt;
  logic             r_blk_done, w_done_nxt;
  logic             r_overrun, w_ovr_nxt;
  logic             r_sync_irq, w_sync_irq_nxt;

  logic             w_bit;
  logic [15:0]      w_word;
  logic             w_match;
  logic             w_start;

  // Only 15 history bits are kept: the incoming bit completes the 16-bit window.
  assign w_bit   = bus.i_clk7_en & bus.i_bit_stb;
  assign w_word  = {r_sr, bus.i_bit_in};
  assign w_match = w_bit & (w_word == bus.i_dsksync);
  assign w_start = bus.i_start & bus.i_dma_en;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_words_left <= '0;
      r_fifo_in    <= '0;
      r_fifo_wr    <= 1'b0;
      r_blk_done   <= 1'b0;
      r_overrun    <= 1'b0;
      r_sync_irq   <= 1'b0;
    end else if (bus.i_clk7_en) begin
      r_state      <= w_state_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_words_left <= w_left_nxt;
      r_fifo_in    <= w_fifo_in_nxt;
      r_fifo_wr    <= w_wr_nxt;
      r_blk_done   <= w_done_nxt;
      r_overrun    <= w_ovr_nxt;
      r_sync_irq   <= w_sync_irq_nxt;
      if (w_bit) r_sr <= w_word[14:0];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_left_nxt    = r_words_left;
    w_fifo_in_nxt = r_fifo_in;
    w_wr_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    w_ovr_nxt     = r_overrun;
`ifdef FLOPPY_SYNC_IRQ_EN
    w_sync_irq_nxt = w_match;
`else
    w_sync_irq_nxt = 1'b0;
`endif

    if (w_start) begin
      w_bitcnt_nxt = '0;
      w_left_nxt   = bus.i_len;
      w_ovr_nxt    = 1'b0;
      if (bus.i_len == '0) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = bus.i_wordsync ? S_HUNT : S_XFER;
      end
    end else if (r_state != S_IDLE && !bus.i_dma_en) begin
      w_state_nxt  = S_IDLE;
      w_bitcnt_nxt = '0;
    end else if (w_bit) begin
      case (r_state)
        S_HUNT: begin
          if (w_match) begin
            w_state_nxt  = S_XFER;
            w_bitcnt_nxt = '0;
          end
        end
        S_XFER: begin
          // A resync beats a word that would complete on the same bit.
          if (bus.i_wordsync && w_match) begin
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd15) begin
              if (bus.i_fifo_full) begin
                w_ovr_nxt = 1'b1;
              end else begin
                w_fifo_in_nxt = w_word;
                w_wr_nxt      = 1'b1;
                if (r_words_left != '0) w_left_nxt = r_words_left - LEN_W'(1);
                if (r_words_left <= LEN_W'(1)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_fifo_in    = r_fifo_in;
  assign bus.o_fifo_wr    = r_fifo_wr;
  assign bus.o_busy       = (r_state == S_HUNT) || (r_state == S_XFER);
  assign bus.o_words_left = r_words_left;
  assign bus.o_blk_done   = r_blk_done;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_sync_irq   = r_sync_irq;

endmodule
